// File: rtl/tdm_demux.sv
// tdm_demux - time-division demultiplexer with frame-alignment tracking.
//
// Splits one interleaved word stream (NUM_CH slots per frame, slot 0 marked by
// in_sof) into NUM_CH registered channel outputs, each with a one-cycle
// update strobe. A two-state lock FSM (HUNT / LOCKED) follows frame alignment:
// an early SOF resynchronises in place, a missing SOF drops back to HUNT.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     input word present this cycle
//   in_data      slot word (WIDTH bits)
//   in_sof       slot-0 marker, qualified by in_valid
//   out_data     channel i at bits [i*WIDTH +: WIDTH], holds last value
//   out_valid    bit i pulses when channel i is written
//   frame_valid  pulses when the last slot of an aligned frame is written
//   locked       high while in LOCKED
//   sync_err     pulses on an early or missing SOF
//   err_cnt      saturating sync_err count (only with TDM_DEMUX_ERR_CNT_EN)
//
// Optional feature macro: TDM_DEMUX_ERR_CNT_EN (adds err_cnt port/register).

module tdm_demux #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_sof,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  output logic                    frame_valid,
  output logic                    locked,
`ifdef TDM_DEMUX_ERR_CNT_EN
  output logic [7:0]              err_cnt,
`endif
  output logic                    sync_err
);

  localparam int SW = $clog2(NUM_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);
  localparam logic [SW-1:0] ONE_SLOT  = SW'(1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     slot_reg, slot_next;
  logic              wr_en;
  logic [SW-1:0]     wr_ch;
  logic              frame_next;
  logic              err_next;
  logic [NUM_CH-1:0] valid_next;
  logic [NUM_CH-1:0] valid_reg;
  logic              frame_reg;
  logic              err_reg;

  // State and slot counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= HUNT;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // Next-state logic; decides which channel (if any) this beat writes.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    wr_en      = 1'b0;
    wr_ch      = '0;
    frame_next = 1'b0;
    err_next   = 1'b0;
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (in_sof) begin
            wr_en      = 1'b1;
            slot_next  = ONE_SLOT;
            state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof) begin
            // Early SOF flags an error but is still taken as slot 0.
            err_next  = (slot_reg != '0);
            wr_en     = 1'b1;
            slot_next = ONE_SLOT;
          end else if (slot_reg == '0) begin
            // Slot 0 arrived without its marker: alignment lost.
            err_next   = 1'b1;
            state_next = HUNT;
          end else begin
            wr_en      = 1'b1;
            wr_ch      = slot_reg;
            frame_next = (slot_reg == LAST_SLOT);
            slot_next  = (slot_reg == LAST_SLOT) ? '0 : slot_reg + ONE_SLOT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  // Per-channel data registers; only the addressed channel loads.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] ch_reg;
      assign valid_next[gi] = wr_en && (wr_ch == SW'(gi));
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ch_reg <= '0;
        end else if (valid_next[gi]) begin
          ch_reg <= in_data;
        end
      end
      assign out_data[gi*WIDTH +: WIDTH] = ch_reg;
    end
  endgenerate

  // Strobe registers, coincident with the data update of the same beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= '0;
      frame_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      frame_reg <= frame_next;
      err_reg   <= err_next;
    end
  end

  assign out_valid   = valid_reg;
  assign frame_valid = frame_reg;
  assign sync_err    = err_reg;
  assign locked      = (state_reg == LOCKED);

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_reg <= '0;
    end else if (err_next && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end
  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux - drives a NUM_CH=2 and a NUM_CH=4 instance with the same beat
// stream and compares both against a frame-level reference model.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_sof = 1'b0;

  logic [15:0] d2_data;
  logic [1:0]  d2_valid;
  logic        d2_fv, d2_lock, d2_err;
  logic [31:0] d4_data;
  logic [3:0]  d4_valid;
  logic        d4_fv, d4_lock, d4_err;
  logic [7:0]  d2_cnt, d4_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8), .NUM_CH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data(d2_data), .out_valid(d2_valid), .frame_valid(d2_fv), .locked(d2_lock),
`ifdef TDM_DEMUX_ERR_CNT_EN
    .err_cnt(d2_cnt),
`endif
    .sync_err(d2_err));

  tdm_demux #(.WIDTH(8), .NUM_CH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data(d4_data), .out_valid(d4_valid), .frame_valid(d4_fv), .locked(d4_lock),
`ifdef TDM_DEMUX_ERR_CNT_EN
    .err_cnt(d4_cnt),
`endif
    .sync_err(d4_err));

`ifndef TDM_DEMUX_ERR_CNT_EN
  assign d2_cnt = '0;
  assign d4_cnt = '0;
`endif

  // Reference model: per instance, alignment flag, expected next slot,
  // channel contents, last-beat strobes and error total.
  int         nch [2] = '{2, 4};
  bit         m_lock [2];
  int         m_pos [2];
  int         m_cnt [2];
  logic [7:0] m_ch [2][4];
  logic [3:0] m_ov [2];
  bit         m_fv [2];
  bit         m_err [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lock[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
      m_ov[k] = '0; m_fv[k] = 0; m_err[k] = 0;
      for (int c = 0; c < 4; c++) m_ch[k][c] = '0;
    end
  endtask

  task automatic model_beat(input bit v, input logic [7:0] d, input bit s);
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = '0; m_fv[k] = 0; m_err[k] = 0;
      if (v) begin
        if (s) begin
          m_err[k] = m_lock[k] && (m_pos[k] != 0);
          m_lock[k] = 1;
          m_ch[k][0] = d; m_ov[k] = 4'b0001; m_pos[k] = 1;
        end else if (m_lock[k]) begin
          if (m_pos[k] == 0) begin
            m_err[k] = 1; m_lock[k] = 0;
          end else begin
            m_ch[k][m_pos[k]] = d;
            m_ov[k] = 4'(1 << m_pos[k]);
            m_fv[k] = (m_pos[k] == nch[k] - 1);
            m_pos[k] = (m_pos[k] + 1) % nch[k];
          end
        end
        if (m_err[k] && m_cnt[k] < 255) m_cnt[k]++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e2, e4;
    e2 = {16'h0, m_ch[0][1], m_ch[0][0]};
    e4 = {m_ch[1][3], m_ch[1][2], m_ch[1][1], m_ch[1][0]};
    chk("ch2_data",  {16'h0, d2_data}, e2);
    chk("ch2_valid", {30'h0, d2_valid}, {30'h0, m_ov[0][1:0]});
    chk("ch2_fv",    {31'h0, d2_fv},   {31'h0, m_fv[0]});
    chk("ch2_lock",  {31'h0, d2_lock}, {31'h0, m_lock[0]});
    chk("ch2_err",   {31'h0, d2_err},  {31'h0, m_err[0]});
    chk("ch4_data",  d4_data, e4);
    chk("ch4_valid", {28'h0, d4_valid}, {28'h0, m_ov[1]});
    chk("ch4_fv",    {31'h0, d4_fv},   {31'h0, m_fv[1]});
    chk("ch4_lock",  {31'h0, d4_lock}, {31'h0, m_lock[1]});
    chk("ch4_err",   {31'h0, d4_err},  {31'h0, m_err[1]});
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("ch2_cnt", {24'h0, d2_cnt}, 32'(m_cnt[0]));
    chk("ch4_cnt", {24'h0, d4_cnt}, 32'(m_cnt[1]));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_d2"}, {16'h0, d2_data} | {30'h0, d2_valid} | {31'h0, d2_fv | d2_lock | d2_err} | {24'h0, d2_cnt}, 32'h0);
    chk({tag, "_d4"}, d4_data | {28'h0, d4_valid} | {31'h0, d4_fv | d4_lock | d4_err} | {24'h0, d4_cnt}, 32'h0);
  endtask

  // One clock cycle with the given inputs, then model update and full check.
  task automatic beat(input bit v, input logic [7:0] d, input bit s);
    in_valid = v; in_data = d; in_sof = s;
    @(posedge clk);
    #1;
    model_beat(v, d, s);
    check_all();
    $display("[TB] beat v=%0d d=%h sof=%0d | d2 data=%h ov=%b fv=%0d lk=%0d err=%0d | d4 data=%h ov=%b fv=%0d lk=%0d err=%0d",
             v, d, s, d2_data, d2_valid, d2_fv, d2_lock, d2_err, d4_data, d4_valid, d4_fv, d4_lock, d4_err);
  endtask

  initial begin
    model_reset();
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Hunt discard: no SOF seen yet.
    beat(1, 8'h11, 0);
    beat(1, 8'h22, 0);
    chk("hunt_valid", {30'h0, d2_valid}, 32'h0);
    chk("hunt_data",  {16'h0, d2_data}, 32'h0);

    // Reset then lock.
    beat(1, 8'hA5, 1);
    chk("lock_ov0", {30'h0, d2_valid}, 32'h1);
    beat(1, 8'h3C, 0);
    chk("lock_ov1",  {30'h0, d2_valid}, 32'h2);
    chk("lock_data", {16'h0, d2_data}, 32'h3CA5);
    chk("lock_fv",   {31'h0, d2_fv}, 32'h1);
    chk("lock_lk",   {31'h0, d2_lock}, 32'h1);

    // Idle gaps inside a frame.
    beat(1, 8'h01, 1);
    repeat (3) beat(0, 8'hEE, 1);
    beat(1, 8'h02, 0);
    chk("idle_ch1", {24'h0, d2_data[15:8]}, 32'h02);
    chk("idle_fv",  {31'h0, d2_fv}, 32'h1);

    // Early SOF on the four-channel instance.
    beat(1, 8'h10, 1);
    beat(1, 8'h20, 0);
    beat(1, 8'h30, 1);
    chk("early_err", {31'h0, d4_err}, 32'h1);
    chk("early_ov",  {28'h0, d4_valid}, 32'h1);
    chk("early_ch0", {24'h0, d4_data[7:0]}, 32'h30);
    chk("early_fv",  {31'h0, d4_fv}, 32'h0);
    beat(1, 8'h40, 0);
    chk("early_ch1", {28'h0, d4_valid}, 32'h2);

    // Missing SOF on the two-channel instance.
    beat(1, 8'hAA, 1);
    beat(1, 8'hBB, 0);
    beat(1, 8'hCC, 0);
    chk("miss_err",  {31'h0, d2_err}, 32'h1);
    chk("miss_data", {16'h0, d2_data}, 32'hBBAA);
    chk("miss_lk",   {31'h0, d2_lock}, 32'h0);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("miss_cnt",  {24'h0, d2_cnt}, 32'h1);
`endif

    // Asynchronous reset between slot 0 and slot 1.
    beat(1, 8'h55, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    #2 rst = 1'b0;
    beat(1, 8'h66, 0);

    // Randomised stream.
    for (int i = 0; i < 200; i++)
      beat($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0);

    // Repeated early SOFs drive the error counter into saturation.
    for (int i = 0; i < 301; i++) beat(1, 8'(i), 1);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("sat_cnt2", {24'h0, d2_cnt}, 32'd255);
    chk("sat_cnt4", {24'h0, d4_cnt}, 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive-side counterpart of the channel multiplexers. It takes one word stream carrying NUM_CH interleaved channel slots, marked by a start-of-frame flag on slot 0. Each slot is routed into a registered per-channel output with a one-cycle valid strobe. It tracks frame alignment with a two-state lock FSM and flags misaligned start-of-frame markers.

## Interface
- WIDTH, 8, data bits per slot/channel
- NUM_CH, 2, slots per frame (≥2); slot counter width SW = $clog2(NUM_CH)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present this cycle
- in_data  input  WIDTH  slot word
- in_sof  input  1  marks slot 0 of a frame; qualified by in_valid
- out_data  output  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH], registered, holds last value
- out_valid  output  NUM_CH  bit i pulses one cycle when channel i is updated
- frame_valid  output  1  one-cycle pulse when slot NUM_CH-1 of an aligned frame is written
- locked  output  1  high in state LOCKED
- sync_err  output  1  one-cycle pulse on alignment error
- err_cnt  output  8  saturating error count; present only with TDM_DEMUX_ERR_CNT_EN

## Operation
- Accepted beat: in_valid=1 on a rising clk edge. in_sof is ignored when in_valid=0.
- State HUNT (reset state):
  - beat with in_sof=1: write in_data to ch0, pulse out_valid[0], set slot_cnt=1, go to LOCKED.
  - beat with in_sof=0: discard it; no output change, no sync_err.
- State LOCKED:
  - beat with in_sof=0 and slot_cnt≠0: write channel slot_cnt, pulse its out_valid bit.
    - If slot_cnt=NUM_CH-1, also pulse frame_valid.
    - slot_cnt wraps to 0 after NUM_CH-1.
  - beat with in_sof=1 and slot_cnt=0: normal slot 0; write ch0, slot_cnt=1.
  - beat with in_sof=1 and slot_cnt≠0 (early SOF): resync.
    - Pulse sync_err; the partial frame gets no frame_valid.
    - Treat the beat as slot 0: write ch0, pulse out_valid[0], slot_cnt=1, stay LOCKED.
  - beat with in_sof=0 and slot_cnt=0 (missing SOF): pulse sync_err, discard the beat, slot_cnt=0, go to HUNT.
- Writes happen only on accepted beats; idle cycles (in_valid=0) hold all state, and strobes are 0.
- Only one channel is written per cycle; out_valid is one-hot or zero.

## Timing
- Reset values: out_data=0, out_valid=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0, slot_cnt=0, state=HUNT.
- Latency: a beat accepted at edge N appears on out_data/out_valid at edge N (registered outputs), visible in the cycle after the input cycle. frame_valid and sync_err are coincident with the out_valid of the same beat.
- locked rises in the cycle after the first aligned SOF is accepted, and falls in the cycle after a missing-SOF beat.
- Back-to-back beats are fully supported (one per cycle); no backpressure.
- Reset asserted mid-frame clears everything immediately (asynchronously). The first post-reset frame requires an SOF.

## Configuration
- TDM_DEMUX_ERR_CNT_EN defined:
  - err_cnt port exists and increments on every sync_err pulse.
  - Saturates at 255; cleared only by rst.
- Undefined: no err_cnt port or register; all other behaviour is identical.

## Test plan
- Reset then lock (WIDTH=8, NUM_CH=2): beats (A5,sof=1),(3C,sof=0) back-to-back.
  - Required: out_valid=01 then 10; out_data=0x3CA5 after the second; frame_valid pulses with the second beat; locked=1.
- Hunt discard: beats (11,sof=0),(22,sof=0) before any SOF.
  - Required: out_valid stays 0, out_data=0, sync_err=0, locked=0.
- Idle gaps: frame (01,sof=1), three idle cycles, (02,sof=0).
  - Required: ch1=02 written on the last beat; frame_valid pulses once; no strobes during the idle cycles.
- Early SOF (NUM_CH=4): locked after (10,sof=1),(20,0), then (30,sof=1).
  - Required: sync_err pulses; ch0=30; out_valid=0001; no frame_valid; next (40,0) writes ch1.
- Missing SOF: after full frame (AA,1),(BB,0), beat (CC,sof=0).
  - Required: sync_err pulses; out_data unchanged at 0xBBAA; locked=0; err_cnt=1 with TDM_DEMUX_ERR_CNT_EN.
- Async reset mid-frame, plus saturation:
  - rst asserted between slot 0 and slot 1. Required: all outputs 0 before the next clk edge.
  - With TDM_DEMUX_ERR_CNT_EN, 300 forced errors. Required: err_cnt=255.
